sync_fifo_prog: RTL and testbench

Parametrised synchronous FIFO, successor to the fixed 16x8 design-lab FIFO. Adds arbitrary (non-power-of-two) depth, selectable standard or first-word-fall-through (FWFT) read mode, runtime-programmable almost-full/almost-empty thresholds, a synchronous flush, an occupancy output, and accepted simultaneous read/write when full. Single clock domain; sits between a producer and consumer block in the same clock domain.

---
 rtl/sync_fifo_prog.sv | 123 ++++++++++++
 tb/tb_sync_fifo_prog.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: parametrised single-clock FIFO with arbitrary depth,
// standard or first-word-fall-through read port, live almost-full/empty
// thresholds, synchronous flush and occupancy output.
module sync_fifo_prog #(
  parameter int  FIFO_WIDTH = 16,
  parameter int  FIFO_DEPTH = 8,
  parameter int  FWFT       = 0,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;

  // Acceptance: a pop frees the slot a simultaneous push needs when full.
  always_comb begin
    w_rd_acc     = rd_en && (r_count != '0);
    w_wr_acc     = wr_en && ((r_count < DEPTH_CNT) || w_rd_acc);
    w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
    w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
  end

  // Storage array: written only on accepted writes, never cleared.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and one-cycle handshake pulses.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      r_count     <= r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= wr_en && !w_wr_acc;
      r_underflow <= rd_en && !w_rd_acc;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [FIFO_WIDTH-1:0] r_data_out;
      logic                  r_data_valid;

      // Registered read port: popped word lands after the accepting edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data_out   <= '0;
          r_data_valid <= 1'b0;
        end else if (flush) begin
          r_data_valid <= 1'b0;
        end else begin
          r_data_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
          end
        end
      end

      assign data_out   = r_data_out;
      assign data_valid = r_data_valid;
    end else begin : g_fwft
      // Head word is always presented; a pop just advances the pointer.
      assign data_out   = r_mem[r_rd_ptr];
      assign data_valid = (r_count != '0);
    end
  endgenerate

  assign count       = r_count;
  assign full        = (r_count == DEPTH_CNT);
  assign empty       = (r_count == '0);
  assign almostfull  = (r_count >= af_thresh);
  assign almostempty = (r_count <= ae_thresh);
  assign wr_ack      = r_wr_ack;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: drives a standard-mode depth-5 FIFO and an FWFT
// depth-8 FIFO with the same stimulus and compares both against
// queue-based reference models.
module tb_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic        flush;
  logic [2:0]  af0, ae0;
  logic [3:0]  af1, ae1;

  logic [15:0] d0_dout, d1_dout;
  logic        d0_dv, d1_dv;
  logic [2:0]  d0_cnt;
  logic [3:0]  d1_cnt;
  logic        d0_full, d0_empty, d0_af, d0_ae, d0_ack, d0_ovf, d0_unf;
  logic        d1_full, d1_empty, d1_af, d1_ae, d1_ack, d1_ovf, d1_unf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state per instance: 0 = standard/depth 5, 1 = FWFT/depth 8.
  logic [15:0] mq [2][$];
  logic [15:0] m_dout [2];
  bit          m_dv [2];
  bit          m_ack [2];
  bit          m_ovf [2];
  bit          m_unf [2];

  always #5 clk = ~clk;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .af_thresh(af0), .ae_thresh(ae0),
    .data_out(d0_dout), .data_valid(d0_dv), .count(d0_cnt),
    .full(d0_full), .empty(d0_empty), .almostfull(d0_af), .almostempty(d0_ae),
    .wr_ack(d0_ack), .overflow(d0_ovf), .underflow(d0_unf)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .af_thresh(af1), .ae_thresh(ae1),
    .data_out(d1_dout), .data_valid(d1_dv), .count(d1_cnt),
    .full(d1_full), .empty(d1_empty), .almostfull(d1_af), .almostempty(d1_ae),
    .wr_ack(d1_ack), .overflow(d1_ovf), .underflow(d1_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 5 : 8;
  endfunction

  // Advance both reference models by one clock using the sampled inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit ra;
      bit wa;
      if (rst) begin
        mq[k].delete();
        m_dout[k] = '0;
        m_dv[k] = 0; m_ack[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end else if (flush) begin
        mq[k].delete();
        m_dv[k] = 0; m_ack[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end else begin
        ra = rd_en && (mq[k].size() != 0);
        wa = wr_en && ((mq[k].size() < depth_of(k)) || ra);
        m_dv[k] = ra;
        if (ra) m_dout[k] = mq[k].pop_front();
        if (wa) mq[k].push_back(data_in);
        m_ack[k] = wa;
        m_ovf[k] = wr_en && !wa;
        m_unf[k] = rd_en && !ra;
      end
    end
  endtask

  task automatic check_all();
    int sz;
    sz = mq[0].size();
    check("std_count", 32'(d0_cnt), sz);
    check("std_full", d0_full, sz == 5);
    check("std_empty", d0_empty, sz == 0);
    check("std_af", d0_af, sz >= int'(af0));
    check("std_ae", d0_ae, sz <= int'(ae0));
    check("std_ack", d0_ack, m_ack[0]);
    check("std_ovf", d0_ovf, m_ovf[0]);
    check("std_unf", d0_unf, m_unf[0]);
    check("std_dv", d0_dv, m_dv[0]);
    check("std_dout", d0_dout, m_dout[0]);
    sz = mq[1].size();
    check("fwft_count", 32'(d1_cnt), sz);
    check("fwft_full", d1_full, sz == 8);
    check("fwft_empty", d1_empty, sz == 0);
    check("fwft_af", d1_af, sz >= int'(af1));
    check("fwft_ae", d1_ae, sz <= int'(ae1));
    check("fwft_ack", d1_ack, m_ack[1]);
    check("fwft_ovf", d1_ovf, m_ovf[1]);
    check("fwft_unf", d1_unf, m_unf[1]);
    check("fwft_dv", d1_dv, sz != 0);
    if (sz != 0) check("fwft_dout", d1_dout, mq[1][0]);
  endtask

  // Drive one cycle of stimulus, step the models, then compare.
  task automatic cycle(input bit we, input bit re, input bit fl, input bit rs,
                       input logic [15:0] din);
    wr_en = we; rd_en = re; flush = fl; rst = rs; data_in = din;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    af0 = 3'd4; ae0 = 3'd1; af1 = 4'd6; ae1 = 4'd2;
    cycle(0, 0, 0, 1, 16'h0);
    cycle(0, 0, 0, 1, 16'h0);
    check("rst_std_empty", d0_empty, 1);
    check("rst_fwft_dv", d1_dv, 0);

    // Fill depth-5 FIFO, then overflow it.
    for (int i = 1; i <= 5; i++) cycle(1, 0, 0, 0, 16'(i));
    check("std_full_at5", d0_full, 1);
    cycle(1, 0, 0, 0, 16'h0006);
    check("std_overflow6", d0_ovf, 1);
    check("std_count_hold5", 32'(d0_cnt), 5);

    // Drain in order, then a second pass to exercise pointer wrap.
    for (int i = 1; i <= 5; i++) begin
      cycle(0, 1, 0, 0, 16'h0);
      check("std_order", d0_dout, i);
    end
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 16'(16'h0011 + i));
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 16'h0);
    check("std_wrap_last", d0_dout, 16'h0015);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 16'h0);

    // Simultaneous read/write while full.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 16'(16'h0021 + i));
    cycle(1, 1, 0, 0, 16'hBEEF);
    check("full_rw_ack", d0_ack, 1);
    check("full_rw_ovf", d0_ovf, 0);
    check("full_rw_count", 32'(d0_cnt), 5);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 16'h0);
    check("beef_last", d0_dout, 16'hBEEF);

    // Simultaneous read/write while empty.
    cycle(1, 1, 0, 0, 16'h0077);
    check("empty_rw_unf", d0_unf, 1);
    check("empty_rw_ack", d0_ack, 1);
    check("empty_rw_count", 32'(d0_cnt), 1);
    check("empty_rw_dv", d0_dv, 0);
    cycle(0, 1, 0, 0, 16'h0);

    // Flush at count 4 with a write pending.
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 16'(16'h0031 + i));
    cycle(1, 0, 1, 0, 16'h0099);
    check("flush_count", 32'(d0_cnt), 0);
    check("flush_empty", d0_empty, 1);
    check("flush_ack", d0_ack, 0);

    // FWFT visibility right after the write edge.
    cycle(1, 0, 0, 0, 16'hA5A5);
    check("fwft_a5_dout", d1_dout, 16'hA5A5);
    check("fwft_a5_dv", d1_dv, 1);
    cycle(0, 1, 0, 0, 16'h0);
    check("fwft_pop_empty", d1_empty, 1);
    check("fwft_pop_dv", d1_dv, 0);

    // Threshold sweep on the depth-8 FIFO, then a live threshold change.
    af1 = 4'd6; ae1 = 4'd2;
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 16'(16'h0041 + i));
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 16'h0);
    check("fwft_af_at4", d1_af, 0);
    af1 = 4'd3;
    #1;
    check("fwft_af_live", d1_af, 1);

    // Reset in the middle of a write burst.
    cycle(1, 0, 0, 0, 16'h0051);
    cycle(1, 0, 0, 1, 16'h0052);
    check("rst_mid_count", 32'(d1_cnt), 0);
    check("rst_mid_ack", d0_ack, 0);
    check("rst_mid_dout", d0_dout, 0);

    // Randomized traffic with phase-varying bias, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      int rp;
      case ((i / 200) % 3)
        0:       begin wp = 75; rp = 30; end
        1:       begin wp = 30; rp = 75; end
        default: begin wp = 55; rp = 55; end
      endcase
      if (i % 50 == 0) begin
        af0 = 3'($urandom_range(0, 6)); ae0 = 3'($urandom_range(0, 6));
        af1 = 4'($urandom_range(0, 9)); ae1 = 4'($urandom_range(0, 9));
      end
      cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
            $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0,
            16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
